cpu_trace_buffer: RTL

// - Parametrised debug trace capture for the CPU core. Snapshots the debug bus (pc, instr, R0, R1, RAM[3]) on each

---
 rtl/cpu_trace_buffer.sv | 117 +++++++++++
 1 files changed

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular capture of the CPU debug bus with a PC/instruction trigger,
// a programmable post-trigger window and an oldest-first valid/ready drain port.
module cpu_trace_buffer #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 8,
  parameter int REG_W   = 4,
  parameter int DEPTH   = 16,
  parameter int POST    = 4,
  parameter int REC_W   = PC_W + INSTR_W + 3 * REG_W,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               abort,
  input  logic               smp_valid,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [REG_W-1:0]   r0_in,
  input  logic [REG_W-1:0]   r1_in,
  input  logic [REG_W-1:0]   ram3_in,
  input  logic               trig_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [INSTR_W-1:0] trig_instr,
  input  logic [INSTR_W-1:0] trig_mask,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [REC_W-1:0]   rd_data,
  output logic               rd_last,
  output logic [1:0]         state,
  output logic [AW:0]        count,
  output logic               triggered
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_POST = 2'd2;
  localparam logic [1:0] S_DUMP = 2'd3;
  logic [REC_W-1:0] r_mem [DEPTH];
  logic [1:0]       r_state;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_post_cnt;
  logic [AW:0]      r_count;
  logic             r_trig;
  logic             r_rd_valid;
  logic [REC_W-1:0] r_rd_data;
  logic             w_match;
  logic             w_wr;
  logic             w_dump;
  logic [AW-1:0]    w_wr_nxt;
  logic [AW-1:0]    w_rd_nxt;
  logic [AW:0]      w_cnt_nxt;
  assign w_match   = trig_en & smp_valid & (pc_in == trig_pc) & ~|((instr_in ^ trig_instr) & trig_mask);
  assign w_wr      = smp_valid & ~abort & ((r_state == S_PRE) | (r_state == S_POST));
  assign w_wr_nxt  = r_wr_ptr + 1'b1;
  assign w_rd_nxt  = r_rd_ptr + 1'b1;
  assign w_cnt_nxt = (r_count == (AW+1)'(DEPTH)) ? r_count : r_count + 1'b1;
  // Last capture write: trigger itself when there is no post window, else the final post sample.
  assign w_dump    = w_wr & (((r_state == S_PRE) & w_match & (POST == 0)) |
                             ((r_state == S_POST) & (r_post_cnt == AW'(1))));
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= {pc_in, instr_in, r0_in, r1_in, ram3_in};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_post_cnt <= '0;
      r_count    <= '0;
      r_trig     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (abort) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (arm) begin
        r_state  <= S_PRE;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_trig   <= 1'b0;
      end
    end else if (r_state != S_DUMP) begin
      if (w_wr) begin
        r_wr_ptr <= w_wr_nxt;
        r_count  <= w_cnt_nxt;
        if (r_state == S_PRE && w_match) begin
          r_trig     <= 1'b1;
          r_post_cnt <= AW'(POST);
        end
        if (r_state == S_POST) r_post_cnt <= r_post_cnt - 1'b1;
        // Oldest record sits count entries behind the post-write pointer.
        if (w_dump) begin
          r_state  <= S_DUMP;
          r_rd_ptr <= w_wr_nxt - w_cnt_nxt[AW-1:0];
        end else if (r_state == S_PRE && w_match) r_state <= S_POST;
      end
    end else if (!r_rd_valid) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= r_mem[r_rd_ptr];
    end else if (rd_ready) begin
      r_rd_ptr  <= w_rd_nxt;
      r_count   <= r_count - 1'b1;
      r_rd_data <= r_mem[w_rd_nxt];
      if (r_count == (AW+1)'(1)) begin
        r_rd_valid <= 1'b0;
        r_state    <= S_IDLE;
      end
    end
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_valid & (r_count == (AW+1)'(1));
  assign state     = r_state;
  assign count     = r_count;
  assign triggered = r_trig;
endmodule
